// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared store-size encoding and store-align FSM state type
package riscv_core_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef logic [1:0] stalign_state_t;

    localparam stalign_state_t ST_IDLE  = 2'd0;
    localparam stalign_state_t ST_BEAT0 = 2'd1;
    localparam stalign_state_t ST_BEAT1 = 2'd2;

endpackage

// File: rtl/riscv_core_stalign_lane.sv
// rtl/riscv_core_stalign_lane.sv - byte-enable and lane-shifted data for a store spanning up to two words
module riscv_core_stalign_lane
    import riscv_core_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [7:0]  be8,
    output logic [63:0] d64
);

    logic [3:0]  mask;
    logic [31:0] wmasked;

    // Encoding 2'b11 falls through to the word case.
    always_comb begin
        mask    = 4'b1111;
        wmasked = wdata;
        if (size == SZ_BYTE) begin
            mask    = 4'b0001;
            wmasked = {24'h0, wdata[7:0]};
        end else if (size == SZ_HALF) begin
            mask    = 4'b0011;
            wmasked = {16'h0, wdata[15:0]};
        end
    end

    assign be8 = {4'b0000, mask} << off;
    assign d64 = {32'h0, wmasked} << {off, 3'b000};

endmodule

// File: rtl/riscv_core_stalign.sv
// rtl/riscv_core_stalign.sv - splits a store into one or two word-aligned memory write beats
module riscv_core_stalign
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stalign_valid,
    output logic            o_stalign_ready,
    input  logic [1:0]      i_stalign_r_w_size,
    input  logic [XLEN-1:0] i_stalign_addr,
    input  logic [XLEN-1:0] i_stalign_wdata,
    output logic            o_stalign_mem_valid,
    input  logic            i_stalign_mem_ready,
    output logic [XLEN-1:0] o_stalign_mem_addr,
    output logic [XLEN-1:0] o_stalign_mem_wdata,
    output logic [3:0]      o_stalign_mem_be,
    output logic            o_stalign_done,
    output logic            o_stalign_misaligned
);

    stalign_state_t state;
    logic [7:0]     be8;
    logic [63:0]    d64;
    logic [3:0]     hi_be;
    logic [31:0]    hi_wdata;
    logic           accept;
    logic           handshake;

    riscv_core_stalign_lane u_lane (
        .size  (i_stalign_r_w_size),
        .off   (i_stalign_addr[1:0]),
        .wdata (i_stalign_wdata),
        .be8   (be8),
        .d64   (d64)
    );

    assign o_stalign_ready     = (state == ST_IDLE);
    assign o_stalign_mem_valid = (state != ST_IDLE);
    assign accept              = i_stalign_valid && o_stalign_ready;
    assign handshake           = o_stalign_mem_valid && i_stalign_mem_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                <= ST_IDLE;
            o_stalign_mem_addr   <= '0;
            o_stalign_mem_wdata  <= '0;
            o_stalign_mem_be     <= '0;
            hi_be                <= '0;
            hi_wdata             <= '0;
            o_stalign_done       <= 1'b0;
            o_stalign_misaligned <= 1'b0;
        end else begin
            o_stalign_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_stalign_mem_addr   <= {i_stalign_addr[XLEN-1:2], 2'b00};
                        o_stalign_mem_be     <= be8[3:0];
                        o_stalign_mem_wdata  <= d64[31:0];
                        hi_be                <= be8[7:4];
                        hi_wdata             <= d64[63:32];
                        o_stalign_misaligned <= |be8[7:4];
                        state                <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    if (handshake) begin
                        if (o_stalign_misaligned) begin
                            // Address wraps naturally at the top of the address space.
                            o_stalign_mem_addr  <= o_stalign_mem_addr + XLEN'(4);
                            o_stalign_mem_be    <= hi_be;
                            o_stalign_mem_wdata <= hi_wdata;
                            state               <= ST_BEAT1;
                        end else begin
                            o_stalign_mem_addr   <= '0;
                            o_stalign_mem_be     <= '0;
                            o_stalign_mem_wdata  <= '0;
                            o_stalign_done       <= 1'b1;
                            o_stalign_misaligned <= 1'b0;
                            state                <= ST_IDLE;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (handshake) begin
                        o_stalign_mem_addr   <= '0;
                        o_stalign_mem_be     <= '0;
                        o_stalign_mem_wdata  <= '0;
                        o_stalign_done       <= 1'b1;
                        o_stalign_misaligned <= 1'b0;
                        state                <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
